obi_rr_arbiter: RTL and testbench
=================================

# obi_rr_arbiter

Round-robin arbiter that shares one OBI master port among `NUM_REQ` OBI requesters, such as the icache and dcache OBI bridges of several cores, in the scratchpad memory hierarchy. It forwards one request at a time to the downstream slave and holds the selected requester stable until the slave grants it, as OBI requires. It records the requester ID of every granted transaction in an in-order FIFO and uses it to route each `rvalid`/`rdata` back to the requester that issued the transaction.

## Interface
- `NUM_REQ`, default 4: number of upstream requesters, ≥2.
- `MAX_OUTSTANDING`, default 2: maximum number of granted transactions still awaiting `rvalid`, ≥1.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous reset, active-high.
- `req_i`  in  `NUM_REQ`  per-requester OBI `req`.
- `addr_i`  in  `NUM_REQ`×32  per-requester address.
- `we_i`  in  `NUM_REQ`  per-requester write enable.
- `be_i`  in  `NUM_REQ`×4  per-requester byte enables.
- `wdata_i`  in  `NUM_REQ`×32  per-requester write data.
- `gnt_o`  out  `NUM_REQ`  per-requester grant.
- `rvalid_o`  out  `NUM_REQ`  per-requester response valid.
- `rdata_o`  out  32  response data, broadcast to all requesters; qualified by `rvalid_o`.
- `obi_req_o`, `obi_addr_o` (32), `obi_we_o`, `obi_be_o` (4), `obi_wdata_o` (32)  out: downstream request.
- `obi_gnt_i`, `obi_rvalid_i`  in  1: downstream grant and response valid.
- `obi_rdata_i`  in  32: downstream response data.
- `err_o`  out  1  sticky flag: a response arrived while no transaction was outstanding.

## Operation
- **Eligibility.** A requester is eligible when its `req_i` is high and the outstanding FIFO is not full.
- **Selection.**
  - The arbiter picks the first eligible requester, searching upward from the priority pointer `prio` and wrapping modulo `NUM_REQ`.
  - The winner's `addr`/`we`/`be`/`wdata` drive the `obi_*` request outputs, and `obi_req_o` goes high.
- **Lock.**
  - If `obi_req_o` is high and `obi_gnt_i` is low, the block sets `locked` and registers the winner index in `lock_idx`.
  - While `locked`, selection is forced to `lock_idx` regardless of `prio` or other requests.
  - `locked` clears on the grant cycle.
- **Grant.**
  - `gnt_o[w] = obi_gnt_i & obi_req_o`, where `w` is the current winner; the path is combinational.
  - On a grant, the ID `w` is pushed into the FIFO and `prio` becomes `(w+1) mod NUM_REQ`.
- **Response.**
  - When `obi_rvalid_i` is high, `rvalid_o[head]` is asserted, `rdata_o = obi_rdata_i`, and the FIFO pops.
  - `rdata_o` passes `obi_rdata_i` through combinationally at all times.
- **Simultaneous push and pop.**
  - When not full, a grant and an `rvalid` in the same cycle push and pop together; the occupancy count is unchanged.
  - When full, no new request is issued even if an `rvalid` pops in the same cycle; eligibility uses the registered count only.
- **Response with nothing outstanding.** `obi_rvalid_i` with an empty FIFO sets `err_o`, does not pop, and asserts no `rvalid_o`.
- **Full FIFO and lock.** A locked request cannot exist with a full FIFO, because issue is blocked before the request is presented.

## Timing
- **Reset** (synchronous, `rst_i` high at a rising edge):
  - `prio=0`, `locked=0`, FIFO empty, `err_o=0`.
  - All outputs low except `rdata_o`, which is pass-through.
  - Reset mid-transaction drops all outstanding IDs; responses arriving later set `err_o`.
- **Request path.** `req_i` to `obi_req_o` is combinational, with zero cycles of added latency.
- **Response path.** `obi_rvalid_i` to `rvalid_o` is combinational, with zero cycles of added latency.
- **Back-to-back grants.** A new winner may be granted every cycle while the FIFO has space.
- **Arbitration update.** A `prio` update takes effect in the cycle after the grant.
- **Request withdrawal.** A requester dropping `req_i` before its grant violates OBI and is not supported.
- **FIFO.**
  - Depth is `MAX_OUTSTANDING`, with entries of `$clog2(NUM_REQ)` bits.
  - The occupancy count is `$clog2(MAX_OUTSTANDING+1)` bits wide.
  - Read and write pointers wrap modulo the depth.

## Structure
- **Package `obi_arb_pkg`:**
  - `OBI_ADDR_W=32`, `OBI_DATA_W=32`, `OBI_BE_W=4`.
  - Function `rr_pick(req, prio)` returning the winner index and a valid bit.
- **Sub-module `obi_arb_id_fifo`:** a synchronous FIFO with push/pop/full/empty/head ports, parameterized by depth and width.
- **Top level `obi_rr_arbiter`:** holds the arbitration, lock and error logic.

## Test plan
- **Single requester, immediate grant.** `req_i=4'b0100`, `addr_i[2]=0x1000`, `obi_gnt_i=1` in the same cycle; `obi_rvalid_i=1` two cycles later with `rdata=0xDEADBEEF` → `gnt_o=4'b0100` in the request cycle; `obi_addr_o=0x1000`; `rvalid_o=4'b0100` with `rdata_o=0xDEADBEEF`.
- **Round-robin.** All 4 requesting continuously, `obi_gnt_i=1`, responses returned 1 cycle later → grant order 0,1,2,3,0; `rvalid_o` order matches the grant order.
- **Lock under stall.** Requesters 1 and 2 active, `obi_gnt_i=0` for 3 cycles, then 1 → `obi_addr_o` holds requester 1's address through all stall cycles; grant goes to 1, then the next grant goes to 2.
- **Full FIFO.** `MAX_OUTSTANDING=2`, two grants with no `rvalid` → `obi_req_o=0` while any `req_i` is high; in the cycle `rvalid` arrives, still no issue; the next request is issued the following cycle.
- **Spurious response.** `obi_rvalid_i=1` with the FIFO empty → `err_o=1` and stays high until `rst_i`; `rvalid_o=0`.
- **Reset mid-operation.** Assert `rst_i` with 2 transactions outstanding → after reset the FIFO is empty, `prio=0`, and requester 0 wins when all are requesting.

Source files
------------

// File: rtl/obi_arb_pkg.sv
// obi_arb_pkg: shared widths and the round-robin pick function for the OBI arbiter.
// Provides OBI_ADDR_W/OBI_DATA_W/OBI_BE_W, the rr_pick_t result type and rr_pick().
package obi_arb_pkg;
   localparam int OBI_ADDR_W = 32;
   localparam int OBI_DATA_W = 32;
   localparam int OBI_BE_W   = 4;
   localparam int RR_MAX_REQ = 32;
   localparam int RR_IDX_W   = 5;
   typedef struct packed {
      logic                valid;
      logic [RR_IDX_W-1:0] idx;
   } rr_pick_t;
   // First set bit of req at or above prio, wrapping modulo n. Scanning from the
   // farthest offset down lets the nearest hit overwrite the others without a break.
   function automatic rr_pick_t rr_pick(input logic [RR_MAX_REQ-1:0] req, input int n, input int prio);
      rr_pick_t r;
      int       k;
      r = '0;
      for (int i = RR_MAX_REQ - 1; i >= 0; i--) begin
         if (i < n) begin
            k = prio + i;
            if (k >= n) k = k - n;
            if (req[k]) r = '{valid: 1'b1, idx: RR_IDX_W'(k)};
         end
      end
      return r;
   endfunction
endpackage

// File: rtl/obi_arb_id_fifo.sv
// obi_arb_id_fifo: in-order FIFO of granted requester IDs awaiting their response.
// Ports: clk_i/rst_i (sync, active-high), push_i/data_i write, pop_i read,
// head_o oldest entry, full_o/empty_o registered occupancy flags.
module obi_arb_id_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             do_push, do_pop;
   always_comb begin
      full_o  = cnt_q == CW'(DEPTH);
      empty_o = cnt_q == '0;
      head_o  = mem_q[rptr_q];
      do_push = push_i & ~full_o;
      do_pop  = pop_i & ~empty_o;
      wptr_d  = do_push ? (wptr_q == PW'(DEPTH - 1) ? '0 : wptr_q + 1'b1) : wptr_q;
      rptr_d  = do_pop ? (rptr_q == PW'(DEPTH - 1) ? '0 : rptr_q + 1'b1) : rptr_q;
      cnt_d   = (do_push & ~do_pop) ? cnt_q + 1'b1 : (do_pop & ~do_push) ? cnt_q - 1'b1 : cnt_q;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
         if (do_push) mem_q[wptr_q] <= data_i;
      end
   end
endmodule

// File: rtl/obi_rr_arbiter.sv
// obi_rr_arbiter: round-robin share of one OBI master port among NUM_REQ requesters.
// Ports: req/addr/we/be/wdata_i per requester in, gnt_o/rvalid_o per requester out,
// rdata_o broadcast response, obi_* downstream request/response, err_o sticky flag
// for a response that arrives with nothing outstanding.
module obi_rr_arbiter
   import obi_arb_pkg::*;
#(
   parameter int NUM_REQ         = 4,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic [NUM_REQ-1:0]                 req_i,
   input  logic [NUM_REQ-1:0][OBI_ADDR_W-1:0] addr_i,
   input  logic [NUM_REQ-1:0]                 we_i,
   input  logic [NUM_REQ-1:0][OBI_BE_W-1:0]   be_i,
   input  logic [NUM_REQ-1:0][OBI_DATA_W-1:0] wdata_i,
   output logic [NUM_REQ-1:0]                 gnt_o,
   output logic [NUM_REQ-1:0]                 rvalid_o,
   output logic [OBI_DATA_W-1:0]              rdata_o,
   output logic                               obi_req_o,
   output logic [OBI_ADDR_W-1:0]              obi_addr_o,
   output logic                               obi_we_o,
   output logic [OBI_BE_W-1:0]                obi_be_o,
   output logic [OBI_DATA_W-1:0]              obi_wdata_o,
   input  logic                               obi_gnt_i,
   input  logic                               obi_rvalid_i,
   input  logic [OBI_DATA_W-1:0]              obi_rdata_i,
   output logic                               err_o
);
   localparam int IDW = $clog2(NUM_REQ);
   logic [IDW-1:0] prio_q, prio_d, lock_idx_q, lock_idx_d, win, head;
   logic           locked_q, locked_d, err_q, err_d, full, empty, gnt, pop;
   rr_pick_t       pick;
   always_comb begin
      // Eligibility uses the registered full flag, so a same-cycle pop never frees a slot early.
      pick        = rr_pick(RR_MAX_REQ'(req_i & {NUM_REQ{~full}}), NUM_REQ, int'(prio_q));
      // A stalled request stays on the bus until granted; lock overrides arbitration.
      win         = locked_q ? lock_idx_q : IDW'(pick.idx);
      obi_req_o   = locked_q | pick.valid;
      gnt         = obi_req_o & obi_gnt_i;
      gnt_o       = gnt ? NUM_REQ'(1) << win : '0;
      obi_addr_o  = obi_req_o ? addr_i[win] : '0;
      obi_we_o    = obi_req_o & we_i[win];
      obi_be_o    = obi_req_o ? be_i[win] : '0;
      obi_wdata_o = obi_req_o ? wdata_i[win] : '0;
      pop         = obi_rvalid_i & ~empty;
      rvalid_o    = pop ? NUM_REQ'(1) << head : '0;
      rdata_o     = obi_rdata_i;
      prio_d      = gnt ? (win == IDW'(NUM_REQ - 1) ? '0 : win + 1'b1) : prio_q;
      locked_d    = obi_req_o & ~obi_gnt_i;
      lock_idx_d  = win;
      err_d       = err_q | (obi_rvalid_i & empty);
      err_o       = err_q;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prio_q     <= '0;
         lock_idx_q <= '0;
         locked_q   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         prio_q     <= prio_d;
         lock_idx_q <= lock_idx_d;
         locked_q   <= locked_d;
         err_q      <= err_d;
      end
   end
   obi_arb_id_fifo #(
      .DEPTH(MAX_OUTSTANDING),
      .WIDTH(IDW)
   ) u_id_fifo (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .push_i (gnt),
      .data_i (win),
      .pop_i  (pop),
      .head_o (head),
      .full_o (full),
      .empty_o(empty)
   );
endmodule

// File: tb/tb_obi_rr_arbiter.sv
// tb_obi_rr_arbiter: directed stimulus with a response scoreboard for obi_rr_arbiter.
module tb_obi_rr_arbiter;
   logic              clk_i = 1'b0;
   logic              rst_i;
   logic [3:0]        req_i, we_i, gnt_o, rvalid_o;
   logic [3:0][31:0]  addr_i, wdata_i;
   logic [3:0][3:0]   be_i;
   logic [31:0]       rdata_o, obi_addr_o, obi_wdata_o, obi_rdata_i;
   logic              obi_req_o, obi_we_o, obi_gnt_i, obi_rvalid_i, err_o;
   logic [3:0]        obi_be_o;
   typedef struct {
      logic [1:0]  id;
      logic [31:0] data;
   } exp_t;
   exp_t q[$];
   int errors = 0;
   int checks = 0;
   logic [1:0] rr_order [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
   localparam logic [31:0] A0 = 32'hA000_0000, A1 = 32'hA000_0100, A2 = 32'h0000_1000, A3 = 32'hA000_0300;

   always #5 clk_i = ~clk_i;

   obi_rr_arbiter dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .addr_i(addr_i), .we_i(we_i),
      .be_i(be_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
      .obi_req_o(obi_req_o), .obi_addr_o(obi_addr_o), .obi_we_o(obi_we_o), .obi_be_o(obi_be_o),
      .obi_wdata_o(obi_wdata_o), .obi_gnt_i(obi_gnt_i), .obi_rvalid_i(obi_rvalid_i),
      .obi_rdata_i(obi_rdata_i), .err_o(err_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs just after the edge, optionally record the expected
   // response for a transaction granted in this cycle, then wait to the sampling edge.
   task automatic step(input logic [3:0] req, input logic g, input logic rv, input logic [31:0] rd,
                       input logic p, input logic [1:0] id, input logic [31:0] d);
      @(posedge clk_i);
      #1;
      req_i = req;
      obi_gnt_i = g;
      obi_rvalid_i = rv;
      obi_rdata_i = rd;
      if (p) q.push_back('{id: id, data: d});
      @(negedge clk_i);
   endtask

   task automatic do_reset();
      @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      req_i = '0;
      obi_gnt_i = 1'b0;
      obi_rvalid_i = 1'b0;
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      @(negedge clk_i);
   endtask

   // Scoreboard monitor: every routed response must match the oldest recorded grant.
   always @(negedge clk_i) begin
      if (rvalid_o !== 4'b0000) begin
         exp_t e;
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rvalid_unexpected: got rvalid_o=%b, expected 0000", rvalid_o);
         end else begin
            e = q.pop_front();
            chk("rvalid_route", 32'(rvalid_o), 32'(4'b0001 << e.id));
            chk("rdata", rdata_o, e.data);
         end
      end
   end

   initial begin
      rst_i = 1'b1;
      req_i = '0;
      obi_gnt_i = 1'b0;
      obi_rvalid_i = 1'b0;
      obi_rdata_i = '0;
      addr_i = {A3, A2, A1, A0};
      we_i = 4'b0100;
      be_i = {4'h8, 4'h4, 4'h2, 4'h1};
      wdata_i = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
      do_reset();
      chk("rst_gnt", 32'(gnt_o), 0);
      chk("rst_rvalid", 32'(rvalid_o), 0);
      chk("rst_obi_req", 32'(obi_req_o), 0);
      chk("rst_err", 32'(err_o), 0);
      // single requester, immediate grant
      step(4'b0100, 1'b1, 1'b0, 0, 1'b1, 2'd2, 32'hDEAD_BEEF);
      chk("single_gnt", 32'(gnt_o), 32'h4);
      chk("single_req", 32'(obi_req_o), 1);
      chk("single_addr", obi_addr_o, 32'h1000);
      chk("single_we", 32'(obi_we_o), 1);
      chk("single_be", 32'(obi_be_o), 32'h4);
      chk("single_wdata", obi_wdata_o, 32'h2222_2222);
      step(4'b0000, 1'b0, 1'b0, 0, 1'b0, 2'd0, 0);
      chk("single_idle_req", 32'(obi_req_o), 0);
      step(4'b0000, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 2'd0, 0);
      step(4'b0000, 1'b0, 1'b0, 0, 1'b0, 2'd0, 0);
      // round robin, responses one cycle after each grant
      do_reset();
      for (int c = 0; c < 6; c++) begin
         step(c < 5 ? 4'hF : 4'h0, c < 5, c >= 1, 32'hC0DE_0000 + 32'(c) - 1,
              c < 5, c < 5 ? rr_order[c] : 2'd0, 32'hC0DE_0000 + 32'(c));
         chk("rr_gnt", 32'(gnt_o), c < 5 ? 32'(4'b0001 << rr_order[c]) : 0);
      end
      step(4'b0000, 1'b0, 1'b0, 0, 1'b0, 2'd0, 0);
      // lock under stall, then full FIFO
      do_reset();
      step(4'b0110, 1'b0, 1'b0, 0, 1'b0, 2'd0, 0);
      chk("lock_s0_addr", obi_addr_o, A1);
      chk("lock_s0_gnt", 32'(gnt_o), 0);
      step(4'b0110, 1'b0, 1'b0, 0, 1'b0, 2'd0, 0);
      chk("lock_s1_addr", obi_addr_o, A1);
      step(4'b0111, 1'b0, 1'b0, 0, 1'b0, 2'd0, 0);
      chk("lock_s2_addr", obi_addr_o, A1);
      chk("lock_s2_req", 32'(obi_req_o), 1);
      step(4'b0111, 1'b1, 1'b0, 0, 1'b1, 2'd1, 32'h1111_0001);
      chk("lock_gnt1", 32'(gnt_o), 32'h2);
      chk("lock_gnt1_addr", obi_addr_o, A1);
      step(4'b0101, 1'b1, 1'b0, 0, 1'b1, 2'd2, 32'h2222_0002);
      chk("lock_gnt2", 32'(gnt_o), 32'h4);
      chk("lock_gnt2_addr", obi_addr_o, A2);
      step(4'b0001, 1'b1, 1'b0, 0, 1'b0, 2'd0, 0);
      chk("full_req0", 32'(obi_req_o), 0);
      chk("full_gnt0", 32'(gnt_o), 0);
      step(4'b0001, 1'b1, 1'b1, 32'h1111_0001, 1'b0, 2'd0, 0);
      chk("full_pop_req", 32'(obi_req_o), 0);
      chk("full_pop_gnt", 32'(gnt_o), 0);
      step(4'b0001, 1'b1, 1'b0, 0, 1'b1, 2'd0, 32'h0000_00A0);
      chk("full_after_gnt", 32'(gnt_o), 32'h1);
      chk("full_after_addr", obi_addr_o, A0);
      step(4'b0000, 1'b0, 1'b1, 32'h2222_0002, 1'b0, 2'd0, 0);
      step(4'b0000, 1'b0, 1'b1, 32'h0000_00A0, 1'b0, 2'd0, 0);
      step(4'b0000, 1'b0, 1'b0, 0, 1'b0, 2'd0, 0);
      // spurious response
      step(4'b0000, 1'b0, 1'b1, 32'h5, 1'b0, 2'd0, 0);
      chk("spur_rvalid", 32'(rvalid_o), 0);
      step(4'b0000, 1'b0, 1'b0, 0, 1'b0, 2'd0, 0);
      chk("spur_err", 32'(err_o), 1);
      step(4'b0000, 1'b0, 1'b0, 0, 1'b0, 2'd0, 0);
      chk("spur_err_sticky", 32'(err_o), 1);
      // reset with two transactions outstanding
      do_reset();
      chk("mid_rst_err", 32'(err_o), 0);
      step(4'b0001, 1'b1, 1'b0, 0, 1'b0, 2'd0, 0);
      chk("mid_gnt0", 32'(gnt_o), 32'h1);
      step(4'b0010, 1'b1, 1'b0, 0, 1'b0, 2'd0, 0);
      chk("mid_gnt1", 32'(gnt_o), 32'h2);
      do_reset();
      step(4'b0000, 1'b0, 1'b1, 32'hBAD0_0000, 1'b0, 2'd0, 0);
      chk("late_rvalid", 32'(rvalid_o), 0);
      step(4'b0000, 1'b0, 1'b0, 0, 1'b0, 2'd0, 0);
      chk("late_err", 32'(err_o), 1);
      step(4'b1111, 1'b0, 1'b0, 0, 1'b0, 2'd0, 0);
      chk("post_rst_req", 32'(obi_req_o), 1);
      chk("post_rst_addr", obi_addr_o, A0);
      step(4'b1111, 1'b1, 1'b0, 0, 1'b1, 2'd0, 32'hE000_000E);
      chk("post_rst_gnt", 32'(gnt_o), 32'h1);
      step(4'b0000, 1'b0, 1'b1, 32'hE000_000E, 1'b0, 2'd0, 0);
      step(4'b0000, 1'b0, 1'b0, 0, 1'b0, 2'd0, 0);
      chk("queue_drained", 32'(q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
